// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Multi-cycle control sequencer for a MIPS datapath that supports R-type
// (add/sub/and/or/nor), addi, ori, beq and bne. Each instruction walks through
// FETCH -> DECODE -> EXEC_R/EXEC_I -> WB or FETCH -> DECODE -> BRANCH. Illegal
// opcodes park the sequencer in TRAP until reset.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   opcode[5:0]  in   Instr[31:26], sampled in DECODE
//   imem_ready   in   instruction memory data valid this cycle
//   run_en       in   1 = start the next instruction from FETCH
//   pc_write     out  unconditional PC load (PC <= PC+4)
//   pc_write_eq  out  conditional PC load when Zero=1 (beq)
//   pc_write_ne  out  conditional PC load when Zero=0 (bne)
//   pc_source    out  0 = ALU result, 1 = ALUOut (branch target)
//   ir_write     out  instruction register load
//   alu_src_a    out  0 = PC, 1 = ReadData1
//   alu_src_b    out  00 rs2, 01 const 4, 10 sext imm, 11 sext imm<<2
//   alu_op[2:0]  out  000 add, 001 sub, 100 addi, 101 ori, 111 R-type
//   reg_dst      out  0 = rt, 1 = rd
//   reg_write    out  register-file write enable
//   illegal_op   out  sticky trap flag
//   busy         out  low only while parked in FETCH
//
// Optional build macro PERF_COUNTERS_EN adds:
//   cycle_count[31:0]   counts clocks with busy=1 (frozen in TRAP)
//   instr_retired[31:0] counts exits from WB or BRANCH
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int OP_WIDTH   = 6,
  parameter int STATE_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic                imem_ready,
  input  logic                run_en,
  output logic                pc_write,
  output logic                pc_write_eq,
  output logic                pc_write_ne,
  output logic                pc_source,
  output logic                ir_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_op,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                illegal_op,
  output logic                busy
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]         cycle_count,
  output logic [31:0]         instr_retired
`endif
);

  typedef enum logic [STATE_BITS-1:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC_R = 3'd2,
    EXEC_I = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5,
    TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_ORI  = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_BNE  = 3'd4
  } cls_e;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_ORI   = OP_WIDTH'(6'b001101);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_BNE   = OP_WIDTH'(6'b000101);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  // Two-stage arming: both bits clear during reset, so FETCH cannot start an
  // instruction in the reset cycle or in the first full cycle after release.
  logic [1:0] arm_q, arm_d;
  logic       armed;

  assign armed = arm_q[1];
  assign arm_d = {arm_q[0], 1'b1};

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; blocking here would create order races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      cls_q   <= CLS_R;
      arm_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      arm_q   <= arm_d;
    end
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_source   = 1'b0;
    ir_write    = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'b000;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;

    unique case (state_q)
      FETCH: begin
        // While not yet armed all muxes stay at their reset value of 0.
        if (armed) begin
          alu_src_b = 2'b01;
          if (run_en && imem_ready) begin
            pc_write = 1'b1;
            ir_write = 1'b1;
            state_d  = DECODE;
          end
        end
      end
      DECODE: begin
        // Branch target PC + (imm<<2) is precomputed into ALUOut here.
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE: begin cls_d = CLS_R;    state_d = EXEC_R; end
          OP_ADDI:  begin cls_d = CLS_ADDI; state_d = EXEC_I; end
          OP_ORI:   begin cls_d = CLS_ORI;  state_d = EXEC_I; end
          OP_BEQ:   begin cls_d = CLS_BEQ;  state_d = BRANCH; end
          OP_BNE:   begin cls_d = CLS_BNE;  state_d = BRANCH; end
          default:  state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b111;
        state_d   = WB;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (cls_q == CLS_ORI) ? 3'b101 : 3'b100;
        state_d   = WB;
      end
      WB: begin
        // ALU controls repeat the EXEC values so ALUOut stays stable.
        reg_write = 1'b1;
        alu_src_a = 1'b1;
        if (cls_q == CLS_R) begin
          reg_dst = 1'b1;
          alu_op  = 3'b111;
        end else begin
          alu_src_b = 2'b10;
          alu_op    = (cls_q == CLS_ORI) ? 3'b101 : 3'b100;
        end
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = 3'b001;
        pc_source   = 1'b1;
        pc_write_eq = (cls_q == CLS_BEQ);
        pc_write_ne = (cls_q == CLS_BNE);
        state_d     = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: state_d = FETCH;
    endcase
  end

  assign illegal_op = (state_q == TRAP);
  assign busy       = (state_q != FETCH) || (run_en && armed);

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instr_retired_q, instr_retired_d;

  always_comb begin
    cycle_count_d   = cycle_count_q;
    instr_retired_d = instr_retired_q;
    if (busy && (state_q != TRAP)) cycle_count_d = cycle_count_q + 32'd1;
    // WB and BRANCH always leave on the next edge, so being in them is an exit.
    if ((state_q == WB) || (state_q == BRANCH)) instr_retired_d = instr_retired_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count_q   <= 32'd0;
      instr_retired_q <= 32'd0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      instr_retired_q <= instr_retired_d;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign instr_retired = instr_retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Scoreboard bench for multicycle_control_fsm. The driver issues instructions
// and pushes the expected enable events (fetch, write-back, branch) with the
// cycle each must appear in. An independent monitor pops one entry whenever
// the DUT raises any enable and compares controls and timing.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       imem_ready = 1'b0;
  logic       run_en = 1'b0;
  logic       pc_write, pc_write_eq, pc_write_ne, pc_source, ir_write;
  logic       alu_src_a, reg_dst, reg_write, illegal_op, busy;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_retired;
`endif

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .run_en(run_en),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .pc_source(pc_source), .ir_write(ir_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .reg_write(reg_write),
    .illegal_op(illegal_op), .busy(busy)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instr_retired(instr_retired)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;

  typedef struct {
    int unsigned cyc;
    logic        pc_write, pc_write_eq, pc_write_ne, ir_write, reg_write;
    logic        reg_dst, pc_source, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [5:0]  legal_ops [5] = '{OP_R, OP_ADDI, OP_ORI, OP_BEQ, OP_BNE};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic ev_t fetch_event(input int unsigned c);
    ev_t e = '{default: '0};
    e.cyc = c; e.pc_write = 1'b1; e.ir_write = 1'b1; e.alu_src_b = 2'b01;
    return e;
  endfunction

  // Final-cycle event of a legal instruction; for R/I its ALU fields are also
  // the EXEC-cycle controls because WB holds them.
  function automatic ev_t retire_event(input logic [5:0] op, input int unsigned c);
    ev_t e = '{default: '0};
    e.cyc = c;
    e.alu_src_a = 1'b1;
    case (op)
      OP_R:    begin e.reg_write = 1'b1; e.reg_dst = 1'b1; e.alu_op = 3'b111; end
      OP_ADDI: begin e.reg_write = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b100; end
      OP_ORI:  begin e.reg_write = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b101; end
      OP_BEQ:  begin e.pc_write_eq = 1'b1; e.pc_source = 1'b1; e.alu_op = 3'b001; end
      OP_BNE:  begin e.pc_write_ne = 1'b1; e.pc_source = 1'b1; e.alu_op = 3'b001; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [12:0] pack_ev(input ev_t e);
    return {e.pc_write, e.pc_write_eq, e.pc_write_ne, e.ir_write, e.reg_write,
            e.reg_dst, e.pc_source, e.alu_src_a, e.alu_src_b, e.alu_op};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst)
        check("reset_enables", {pc_write, pc_write_eq, pc_write_ne, ir_write, reg_write}, 0);
      else if (pc_write | pc_write_eq | pc_write_ne | ir_write | reg_write) begin
        check("event_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("event_cycle", cyc, mon_e.cyc);
          check("event_controls",
                {pc_write, pc_write_eq, pc_write_ne, ir_write, reg_write,
                 reg_dst, pc_source, alu_src_a, alu_src_b, alu_op}, pack_ev(mon_e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      run_en = 1'b0; imem_ready = 1'($urandom); opcode = 6'($urandom);
      @(negedge clk);
      check("idle_busy", busy, 0);
      step();
    end
  endtask

  // Holds reset two edges, releases on a falling edge, then checks the first
  // full cycle after release cannot start an instruction.
  task automatic post_reset(input bit stress);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_en = stress; imem_ready = stress;
    @(negedge clk);
    check("release_no_write", {pc_write, ir_write, reg_write}, 0);
    if (!stress) check("release_busy", busy, 0);
`ifdef PERF_COUNTERS_EN
    check("reset_cycle_count", cycle_count, 0);
    check("reset_instr_retired", instr_retired, 0);
`endif
    step();
  endtask

  task automatic apply_reset(input bit stress);
    rst = 1'b0; run_en = stress; imem_ready = stress;
    #1;
    check("rst_muxes", {pc_source, alu_src_a, alu_src_b, alu_op, reg_dst}, 0);
    check("rst_illegal", illegal_op, 0);
    if (!stress) check("rst_busy", busy, 0);
    post_reset(stress);
  endtask

  // Caller is at posedge+1 of the first FETCH cycle. abort=1 pulls reset in
  // the EXEC cycle of an R/I instruction.
  task automatic run_instr(input logic [5:0] op, input int waits, input bit abort);
    int unsigned t0;
    bit          is_br, legal;
    ev_t         ex;
    is_br = (op == OP_BEQ) || (op == OP_BNE);
    legal = (op == OP_R) || (op == OP_ADDI) || (op == OP_ORI) || is_br;
    repeat (waits) begin
      run_en = 1'b1; imem_ready = 1'b0; opcode = 6'($urandom);
      step();
    end
    run_en = 1'b1; imem_ready = 1'b1; opcode = 6'($urandom);
    t0 = cyc;
    exp_q.push_back(fetch_event(t0));
    if (legal && !abort) exp_q.push_back(retire_event(op, t0 + (is_br ? 2 : 3)));
    step();
    // DECODE
    opcode = op; run_en = 1'($urandom); imem_ready = 1'($urandom);
    @(negedge clk);
    check("decode_alu", {alu_src_a, alu_src_b, alu_op}, {1'b0, 2'b11, 3'b000});
    check("decode_busy", busy, 1);
    step();
    if (!legal) return;
    opcode = 6'($urandom); run_en = 1'($urandom); imem_ready = 1'($urandom);
    if (abort) begin
      #1 rst = 1'b0; run_en = 1'b0;
      #1;
      check("abort_to_fetch", {alu_src_a, alu_op, reg_write}, 0);
      check("abort_busy", busy, 0);
      post_reset(1'b0);
      return;
    end
    if (!is_br) begin
      ex = retire_event(op, 0);
      @(negedge clk);
      check("exec_alu", {alu_src_a, alu_src_b, alu_op}, {ex.alu_src_a, ex.alu_src_b, ex.alu_op});
      step();
      opcode = 6'($urandom); run_en = 1'($urandom); imem_ready = 1'($urandom);
    end
    step();
  endtask

  // ---------------- test sequence ----------------
`ifdef PERF_COUNTERS_EN
  logic [31:0] frozen;
`endif

  initial begin
    apply_reset(1'b1);

    // 3 addi + 1 beq, no wait states
    repeat (3) run_instr(OP_ADDI, 0, 1'b0);
    run_instr(OP_BEQ, 0, 1'b0);
    idle(2);
`ifdef PERF_COUNTERS_EN
    check("perf_instr_retired", instr_retired, 4);
    check("perf_cycle_count", cycle_count, 15);
`endif

    // R-type with three wait states, then beq / bne back to back
    run_instr(OP_R, 3, 1'b0);
    run_instr(OP_BEQ, 0, 1'b0);
    run_instr(OP_BNE, 0, 1'b0);
    run_instr(OP_ORI, 1, 1'b0);
    idle(1);

    // randomized legal instruction stream
    for (int i = 0; i < 40; i++) begin
      run_instr(legal_ops[$urandom_range(0, 4)], int'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    // reset in EXEC_R aborts the write-back
    run_instr(OP_R, 0, 1'b1);
    idle(3);

    // illegal opcode traps until reset
    run_instr(OP_LW, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_en = 1'b1; imem_ready = 1'b1; opcode = 6'($urandom);
      @(negedge clk);
      check("trap_illegal_op", illegal_op, 1);
`ifdef PERF_COUNTERS_EN
      if (i == 0) frozen = cycle_count;
`endif
      step();
    end
`ifdef PERF_COUNTERS_EN
    check("trap_counter_frozen", cycle_count, frozen);
`endif
    apply_reset(1'b0);
    run_instr(OP_ADDI, 0, 1'b0);
    idle(2);

`ifdef PERF_COUNTERS_EN
    // counters wrap from all-ones to zero
    @(negedge clk);
    force dut.cycle_count_q = 32'hFFFF_FFFC;
    force dut.instr_retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count_q;
    release dut.instr_retired_q;
    @(posedge clk); #1;
    run_instr(OP_ADDI, 0, 1'b0);
    idle(1);
    check("wrap_cycle_count", cycle_count, 0);
    check("wrap_instr_retired", instr_retired, 0);
`endif

    idle(3);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
